// File: rtl/uart_rx_param_if.sv
// Signal bundle between the UART receive front end and its surroundings.
// The pad/enable side drives rx and rxEn. The receiver (slave modport) returns
// the word, the status flags and a debug copy of its FSM state.
`timescale 1ns/1ps
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    // rxDone is a single-cycle strobe with no back-pressure. out_data, parityErr
    // and frameErr are valid in that cycle and hold until the next strobe.
    logic                 rxEn;
    logic                 rx;
    logic [DATA_BITS-1:0] out_data;
    logic                 rxBusy;
    logic                 rxDone;
    logic                 parityErr;
    logic                 frameErr;
    logic [2:0]           state_dbg;

    modport master (
        output rxEn, rx,
        input  out_data, rxBusy, rxDone, parityErr, frameErr, state_dbg
    );

    modport slave (
        input  rxEn, rx,
        output out_data, rxBusy, rxDone, parityErr, frameErr, state_dbg
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. It synchronises the line and votes on three
// mid-bit samples. It recovers DATA_BITS bits LSB-first, then checks optional
// parity and one or two stop bits.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input logic             clk,
    input logic             rst,
    uart_rx_param_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam int DIV_RAW = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [4:0]  T_V0      = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0]  T_V1      = 5'(OVERSAMPLE / 2);
    localparam logic [4:0]  T_V2      = 5'(OVERSAMPLE / 2 + 1);
    localparam logic [4:0]  T_LAST    = 5'(OVERSAMPLE - 1);
    localparam logic [3:0]  BITS_ALL  = 4'(DATA_BITS);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_prev;
    logic [1:0]           sync_fill;
    logic [15:0]          div_cnt;
    logic [4:0]           tick_cnt;
    logic                 v0;
    logic                 v1;
    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 par_err_r;
    logic                 fr_err_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 perr_r;
    logic                 ferr_r;

    logic tick;
    logic at_vote;
    logic at_end;
    logic voted;
    logic start_go;
    logic par_x;
    logic par_bad;

    // Two-flop synchroniser plus edge history. rxs_prev is held low until the
    // synchroniser carries real pin samples. The reset value of the sync flops
    // therefore never counts as "line seen high".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            sync_fill <= 2'b00;
            rxs_prev  <= 1'b0;
        end else begin
            rx_meta   <= bus.rx;
            rxs       <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            rxs_prev  <= sync_fill[1] ? rxs : 1'b0;
        end
    end

    // Decode the start edge, the tick strobes and the 2-of-3 vote.
    always_comb begin
        start_go = (state == IDLE) && bus.rxEn && rxs_prev && !rxs;
        tick     = (div_cnt == DIV_LAST);
        at_vote  = tick && (tick_cnt == T_V2);
        at_end   = tick && (tick_cnt == T_LAST);
        voted    = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
        par_x    = (^shift_reg) ^ voted;
        par_bad  = (PARITY == 2) ? par_x : ~par_x;
    end

    // Oversampling tick generator, re-phased to the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (start_go) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= (tick_cnt == T_LAST) ? 5'd0 : tick_cnt + 5'd1;
        end else begin
            div_cnt  <= div_cnt + 16'd1;
        end
    end

    // Capture the first two vote samples. The third is the live rxs at at_vote.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b1;
            v1 <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == T_V0) v0 <= rxs;
            if (tick_cnt == T_V1) v1 <= rxs;
        end
    end

    // Frame FSM with registered outputs. The last stop bit finishes at its vote
    // sample, so a start bit that follows immediately is still caught.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_err_r <= 1'b0;
            fr_err_r  <= 1'b0;
            data_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state != IDLE && !bus.rxEn) begin
                state  <= IDLE;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_go) begin
                            state     <= START;
                            busy_r    <= 1'b1;
                            bit_cnt   <= '0;
                            stop_cnt  <= 1'b0;
                            par_err_r <= 1'b0;
                            fr_err_r  <= 1'b0;
                        end
                    end
                    START: begin
                        if (at_vote && voted) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else if (at_end) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (at_vote) begin
                            shift_reg <= {voted, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (at_end && bit_cnt == BITS_ALL) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end
                    end
                    PAR: begin
                        if (at_vote) begin
                            par_err_r <= par_bad;
                        end else if (at_end) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (at_vote) begin
                            if (!voted) fr_err_r <= 1'b1;
                            if (stop_cnt == STOP_LAST) begin
                                data_r <= shift_reg;
                                perr_r <= (PARITY != 0) && par_err_r;
                                ferr_r <= fr_err_r | ~voted;
                                done_r <= 1'b1;
                                busy_r <= 1'b0;
                                state  <= IDLE;
                            end
                        end else if (at_end) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out_data  = data_r;
    assign bus.rxBusy    = busy_r;
    assign bus.rxDone    = done_r;
    assign bus.parityErr = perr_r;
    assign bus.frameErr  = ferr_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param. Instance dut0 uses the default 8N1 format.
// Instance dut1 uses 7 data bits, even parity and 1 stop bit.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int BIT_NS = 8680;

    logic clk;
    logic rst;

    uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_param_if #(.DATA_BITS(7)) bus1 ();

    uart_rx_param dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int total = 0;
    int bad   = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    // Expected {data, parityErr, frameErr}.
    logic [9:0] exp0_q[$];
    logic [8:0] exp1_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int which, input logic b);
        if (which == 0) bus0.rx = b;
        else            bus1.rx = b;
        #(BIT_NS);
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input bit use_par, input logic par_bit, input logic stop_bit);
        drive(which, 1'b0);
        for (int i = 0; i < nbits; i++) drive(which, data[i]);
        if (use_par) drive(which, par_bit);
        drive(which, stop_bit);
    endtask

    // ---------------- scoreboard monitors ----------------
    logic       done0_prev = 1'b0;
    logic [7:0] data0_prev = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.rxDone) begin
                done0_cnt++;
                check("dut0_done_width", {31'd0, done0_prev}, 32'd0);
                if (exp0_q.size() == 0) begin
                    check("dut0_unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("dut0_word", {22'd0, bus0.out_data, bus0.parityErr, bus0.frameErr},
                          {22'd0, exp0_q.pop_front()});
                end
            end else begin
                check("dut0_data_hold", {24'd0, bus0.out_data}, {24'd0, data0_prev});
            end
        end
        done0_prev = bus0.rxDone;
        data0_prev = bus0.out_data;
    end

    logic       done1_prev = 1'b0;
    logic [6:0] data1_prev = 7'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.rxDone) begin
                done1_cnt++;
                check("dut1_done_width", {31'd0, done1_prev}, 32'd0);
                if (exp1_q.size() == 0) begin
                    check("dut1_unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("dut1_word", {23'd0, bus1.out_data, bus1.parityErr, bus1.frameErr},
                          {23'd0, exp1_q.pop_front()});
                end
            end else begin
                check("dut1_data_hold", {25'd0, bus1.out_data}, {25'd0, data1_prev});
            end
        end
        done1_prev = bus1.rxDone;
        data1_prev = bus1.out_data;
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        logic busy_seen;
        rst = 1'b1;
        bus0.rxEn = 1'b1;
        bus0.rx   = 1'b1;
        bus1.rxEn = 1'b1;
        bus1.rx   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_out_data",  {24'd0, bus0.out_data}, 32'd0);
        check("rst_busy",      {31'd0, bus0.rxBusy},    32'd0);
        check("rst_done",      {31'd0, bus0.rxDone},    32'd0);
        check("rst_parityErr", {31'd0, bus0.parityErr}, 32'd0);
        check("rst_frameErr",  {31'd0, bus0.frameErr},  32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // A line that is low coming out of reset must not count as a start.
        bus0.rx = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("low_after_rst_busy", {31'd0, bus0.rxBusy}, 32'd0);
        bus0.rx = 1'b1;
        #(BIT_NS);

        // 8N1 0xB5.
        exp0_q.push_back({8'hB5, 1'b0, 1'b0});
        send_frame(0, 9'h0B5, 8, 1'b0, 1'b0, 1'b1);
        #(BIT_NS);
        check("b5_busy_after", {31'd0, bus0.rxBusy}, 32'd0);

        // Stop bit low, line held low 5 bits: data delivered with frameErr, no restart.
        exp0_q.push_back({8'hA3, 1'b0, 1'b1});
        send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 1'b0);
        busy_seen = 1'b0;
        for (int c = 0; c < 5 * 434; c++) begin
            @(negedge clk);
            if (bus0.rxBusy) busy_seen = 1'b1;
        end
        check("ferr_hold_low_busy", {31'd0, busy_seen}, 32'd0);
        bus0.rx = 1'b1;
        #(BIT_NS);
        exp0_q.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
        #(BIT_NS);

        // 3 us glitch: false start, busy drops after the START vote.
        bus0.rx = 1'b0;
        #3000;
        check("glitch_busy_high", {31'd0, bus0.rxBusy}, 32'd1);
        bus0.rx = 1'b1;
        #8000;
        check("glitch_busy_low", {31'd0, bus0.rxBusy}, 32'd0);
        check("glitch_data_kept", {24'd0, bus0.out_data}, 32'h3C);
        #(BIT_NS);

        // rxEn dropped during data bit 4.
        fork
            send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
            begin
                #(BIT_NS * 11 / 2);
                @(negedge clk);
                check("rxen_busy_before", {31'd0, bus0.rxBusy}, 32'd1);
                bus0.rxEn = 1'b0;
                @(posedge clk);
                #1;
                check("rxen_busy_after", {31'd0, bus0.rxBusy}, 32'd0);
            end
        join
        #(BIT_NS);
        bus0.rxEn = 1'b1;
        check("rxen_data_kept", {24'd0, bus0.out_data}, 32'h3C);
        #(BIT_NS);

        // Reset asserted during data bit 4.
        fork
            send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
            begin
                #(BIT_NS * 11 / 2);
                check("rstmid_busy_before", {31'd0, bus0.rxBusy}, 32'd1);
                rst = 1'b1;
                #1;
                check("rstmid_out_data",  {24'd0, bus0.out_data}, 32'd0);
                check("rstmid_busy",      {31'd0, bus0.rxBusy},    32'd0);
                check("rstmid_done",      {31'd0, bus0.rxDone},    32'd0);
                check("rstmid_parityErr", {31'd0, bus0.parityErr}, 32'd0);
                check("rstmid_frameErr",  {31'd0, bus0.frameErr},  32'd0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        #(BIT_NS);

        // Back-to-back 0x00 then 0xFF, no idle gap.
        exp0_q.push_back({8'h00, 1'b0, 1'b0});
        exp0_q.push_back({8'hFF, 1'b0, 1'b0});
        send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1);
        #(BIT_NS);

        // 7E1: 0x41 has two ones, so the correct even parity bit is 0.
        exp1_q.push_back({7'h41, 1'b1, 1'b0});
        send_frame(1, 9'h041, 7, 1'b1, 1'b1, 1'b1);
        #(BIT_NS);
        exp1_q.push_back({7'h41, 1'b0, 1'b0});
        send_frame(1, 9'h041, 7, 1'b1, 1'b0, 1'b1);
        #(2 * BIT_NS);

        check("dut0_queue_empty", exp0_q.size(), 32'd0);
        check("dut1_queue_empty", exp1_q.size(), 32'd0);
        check("dut0_done_count",  done0_cnt,     32'd5);
        check("dut1_done_count",  done1_cnt,     32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
